// File: rtl/axi_stream_rr_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter's slave and master sides.
// A single instance can carry NumPorts streams packed side by side: stream i
// occupies slice i of every vector. The master side uses NumPorts = 1.
//   tvalid/tready/tlast : one bit per stream
//   tdata               : 8*byte_width bits per stream
//   tstrb/tkeep         : byte_width bits per stream
//   tuser               : user_width bits per stream
//   tid                 : source index, only meaningful on the master side
interface axi_stream_rr_arbiter_if #(
  parameter int unsigned NumPorts   = 1,
  parameter int unsigned byte_width = 4,
  parameter int unsigned user_width = 1,
  parameter int unsigned IdWidth    = 1
);
  logic [NumPorts-1:0]              tvalid;
  logic [NumPorts-1:0]              tready;
  logic [NumPorts*8*byte_width-1:0] tdata;
  logic [NumPorts*byte_width-1:0]   tstrb;
  logic [NumPorts*byte_width-1:0]   tkeep;
  logic [NumPorts-1:0]              tlast;
  logic [NumPorts*user_width-1:0]   tuser;
  logic [IdWidth-1:0]               tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_INPUTS AXI-Stream inputs share one output.
// A port is granted in an IDLE arbitration cycle and stays granted until its TLAST
// beat handshakes, so packets are never interleaved. Each packet costs one bubble.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   s           : slave side, NUM_INPUTS packed streams (arbiter accepts data here)
//   m           : master side, one stream; m.tid carries the granted port index
//   busy        : high while a port holds the grant
module axi_stream_rr_arbiter #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned byte_width = 4,
  parameter int unsigned user_width = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  axi_stream_rr_arbiter_if.slave  s,
  axi_stream_rr_arbiter_if.master m,
  output logic                    busy
);

  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned DataW = 8 * byte_width;
  localparam int unsigned StrbW = byte_width;
  localparam int unsigned UserW = user_width;

  typedef enum logic {
    StIdle,
    StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             req_found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] scan_idx;
  int unsigned      scan_pos;

  // Rotating priority: scan last_grant+1, last_grant+2, ... modulo NUM_INPUTS.
  // The modulo keeps every candidate in range for non power-of-two port counts.
  always_comb begin
    req_found = 1'b0;
    winner    = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned off = 1; off <= NUM_INPUTS; off++) begin
      scan_pos = (32'(last_grant_q) + off) % NUM_INPUTS;
      scan_idx = IDX_W'(scan_pos);
      if (!req_found && s.tvalid[scan_idx]) begin
        req_found = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  // Next state and outputs. Outside LOCKED every output is forced to zero, so
  // the grant can only move while m.tvalid is low.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy         = 1'b0;
    s.tready     = '0;
    m.tvalid     = '0;
    m.tdata      = '0;
    m.tstrb      = '0;
    m.tkeep      = '0;
    m.tlast      = '0;
    m.tuser      = '0;
    m.tid        = '0;

    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          grant_d = winner;
          state_d = StLocked;
        end
      end
      StLocked: begin
        busy              = 1'b1;
        m.tvalid          = s.tvalid[grant_q];
        s.tready[grant_q] = m.tready[0];
        m.tdata           = s.tdata[32'(grant_q) * DataW +: DataW];
        m.tstrb           = s.tstrb[32'(grant_q) * StrbW +: StrbW];
        m.tkeep           = s.tkeep[32'(grant_q) * StrbW +: StrbW];
        m.tlast           = s.tlast[grant_q];
        m.tuser           = s.tuser[32'(grant_q) * UserW +: UserW];
        m.tid             = grant_q;
        // Release only on the TLAST handshake; a tvalid gap keeps the lock.
        if (s.tvalid[grant_q] && m.tready[0] && s.tlast[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // last_grant resets to the top index so the first scan starts at port 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
module tb_axi_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int BW = 4;
  localparam int UW = 1;
  localparam int IW = 2;
  localparam int DW = 8 * BW;

  logic clk;
  logic resetn;
  logic busy;

  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*BW-1:0] s_tstrb;
  logic [N*BW-1:0] s_tkeep;
  logic [N*UW-1:0] s_tuser;
  logic            m_tready;

  axi_stream_rr_arbiter_if #(.NumPorts(N), .byte_width(BW), .user_width(UW), .IdWidth(1)) s_if ();
  axi_stream_rr_arbiter_if #(.NumPorts(1), .byte_width(BW), .user_width(UW), .IdWidth(IW)) m_if ();

  assign s_if.tvalid = s_tvalid;
  assign s_if.tlast  = s_tlast;
  assign s_if.tdata  = s_tdata;
  assign s_if.tstrb  = s_tstrb;
  assign s_if.tkeep  = s_tkeep;
  assign s_if.tuser  = s_tuser;
  assign s_if.tid    = '0;
  assign m_if.tready = m_tready;

  axi_stream_rr_arbiter #(
    .NUM_INPUTS(N),
    .byte_width(BW),
    .user_width(UW)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .s     (s_if),
    .m     (m_if),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-port packet sources.
  int rem[N];
  int beat[N];
  int pktno[N];
  bit hold[N];
  int done_q[$];

  function automatic logic [31:0] pat(input int p, input int pk, input int b);
    return {8'(p), 8'(pk), 16'(b) ^ 16'hA5C3};
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]            = (rem[i] > 0) && !hold[i];
      s_tlast[i]             = (rem[i] == 1);
      s_tdata[i*DW +: DW]    = pat(i, pktno[i], beat[i]);
      s_tstrb[i*BW +: BW]    = 4'(beat[i] + i);
      s_tkeep[i*BW +: BW]    = 4'(pktno[i]) | 4'b0001;
      s_tuser[i*UW +: UW]    = 1'(beat[i] + pktno[i]);
    end
  endtask

  // Reference model: locked flag, owner and previous owner.
  bit mdl_locked;
  int mdl_grant;
  int mdl_last;

  task automatic mdl_reset();
    mdl_locked = 1'b0;
    mdl_grant  = 0;
    mdl_last   = N - 1;
  endtask

  task automatic mdl_update();
    int best;
    int bestd;
    int d;
    if (!mdl_locked) begin
      best  = -1;
      bestd = N;
      // Winner is the requester at the smallest rotational distance after mdl_last.
      for (int p = 0; p < N; p++) begin
        if (s_tvalid[p]) begin
          d = (p - mdl_last - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = p;
          end
        end
      end
      if (best >= 0) begin
        mdl_locked = 1'b1;
        mdl_grant  = best;
      end
    end else if (s_tvalid[mdl_grant] && m_tready && s_tlast[mdl_grant]) begin
      mdl_last   = mdl_grant;
      mdl_locked = 1'b0;
    end
  endtask

  task automatic check_model();
    logic [N-1:0]  e_srdy;
    logic [DW-1:0] e_data;
    logic [BW-1:0] e_strb;
    logic [BW-1:0] e_keep;
    logic [UW-1:0] e_user;
    logic          e_mv;
    logic          e_ml;
    int            g;
    g      = mdl_grant;
    e_srdy = '0;
    e_data = '0;
    e_strb = '0;
    e_keep = '0;
    e_user = '0;
    e_mv   = 1'b0;
    e_ml   = 1'b0;
    if (mdl_locked) begin
      e_srdy[g] = m_tready;
      e_mv      = s_tvalid[g];
      e_ml      = s_tlast[g];
      e_data    = s_tdata[g*DW +: DW];
      e_strb    = s_tstrb[g*BW +: BW];
      e_keep    = s_tkeep[g*BW +: BW];
      e_user    = s_tuser[g*UW +: UW];
    end
    chk("busy", 64'(busy), 64'(mdl_locked));
    chk("m_tvalid", 64'(m_if.tvalid), 64'(e_mv));
    chk("s_tready", 64'(s_if.tready), 64'(e_srdy));
    chk("m_tdata", 64'(m_if.tdata), 64'(e_data));
    chk("m_tlast", 64'(m_if.tlast), 64'(e_ml));
    chk("m_tid", 64'(m_if.tid), mdl_locked ? 64'(g) : 64'd0);
    chk("m_sideband", 64'({m_if.tstrb, m_if.tkeep, m_if.tuser}), 64'({e_strb, e_keep, e_user}));
  endtask

  task automatic settle();
    drive_inputs();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_if.tready[i]) begin
        beat[i]++;
        rem[i]--;
        if (rem[i] == 0) begin
          pktno[i]++;
          beat[i] = 0;
        end
      end
    end
    if (m_if.tvalid[0] && m_tready && m_if.tlast[0]) done_q.push_back(int'(m_if.tid));
    mdl_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic run_until(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (done_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk(name, 64'(done_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i]  = 1;
      beat[i] = 0;
      hold[i] = 1'b0;
    end
    drive_inputs();
    mdl_reset();
    @(negedge clk);
    chk("reset_outputs", 64'({busy, m_if.tvalid, s_if.tready, m_if.tlast, m_if.tid}), 64'd0);
    chk("reset_data", 64'({m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tuser}), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 0;
    done_q.delete();
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [N-1:0] last;
    logic         rdy;
    logic         e_busy;
    logic         e_mv;
    logic         e_ml;
    int           e_tid;
    logic [N-1:0] e_srdy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [N-1:0] vld, input logic [N-1:0] last, input logic rdy,
                              input logic e_busy, input logic e_mv, input logic e_ml,
                              input int e_tid, input logic [N-1:0] e_srdy);
    vec_t v;
    v.vld    = vld;
    v.last   = last;
    v.rdy    = rdy;
    v.e_busy = e_busy;
    v.e_mv   = e_mv;
    v.e_ml   = e_ml;
    v.e_tid  = e_tid;
    v.e_srdy = e_srdy;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e_data;
    for (int i = 0; i < N; i++) begin
      pktno[i] = 0;
      beat[i]  = 0;
      rem[i]   = 0;
      hold[i]  = 1'b0;
    end
    resetn   = 1'b0;
    m_tready = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;

    // Four 2-beat packets requested together: grants 0,1,2,3 with one idle each.
    tbl[0]  = mk(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    tbl[1]  = mk(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 0, 4'b0001);
    tbl[2]  = mk(4'b1111, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0001);
    tbl[3]  = mk(4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    tbl[4]  = mk(4'b1110, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1, 4'b0010);
    tbl[5]  = mk(4'b1110, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1, 4'b0010);
    tbl[6]  = mk(4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    tbl[7]  = mk(4'b1100, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2, 4'b0100);
    tbl[8]  = mk(4'b1100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2, 4'b0100);
    tbl[9]  = mk(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
    tbl[10] = mk(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 3, 4'b1000);
    tbl[11] = mk(4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 3, 4'b1000);

    do_reset();
    for (int i = 0; i < N; i++) begin
      s_tdata[i*DW +: DW] = 32'hC0DE_0000 | 32'(i);
      s_tstrb[i*BW +: BW] = '0;
      s_tkeep[i*BW +: BW] = '0;
      s_tuser[i*UW +: UW] = '0;
    end
    for (int k = 0; k < 12; k++) begin
      s_tvalid = tbl[k].vld;
      s_tlast  = tbl[k].last;
      m_tready = tbl[k].rdy;
      @(negedge clk);
      e_data = tbl[k].e_busy ? (32'hC0DE_0000 | 32'(tbl[k].e_tid)) : 32'd0;
      chk("tbl_busy", 64'(busy), 64'(tbl[k].e_busy));
      chk("tbl_m_tvalid", 64'(m_if.tvalid), 64'(tbl[k].e_mv));
      chk("tbl_m_tlast", 64'(m_if.tlast), 64'(tbl[k].e_ml));
      chk("tbl_m_tid", 64'(m_if.tid), 64'(tbl[k].e_tid));
      chk("tbl_s_tready", 64'(s_if.tready), 64'(tbl[k].e_srdy));
      chk("tbl_m_tdata", 64'(m_if.tdata), 64'(e_data));
      @(posedge clk);
      #1;
    end

    // Port 2 alone, 3 beats, master stalls two cycles on the second beat.
    do_reset();
    rem[2]   = 3;
    m_tready = 1'b1;
    tick();
    tick();
    m_tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("stall_data", 64'(m_if.tdata), 64'(pat(2, pktno[2], 1)));
      chk("stall_last", 64'(m_if.tlast), 64'd0);
      chk("stall_s_tready", 64'(s_if.tready), 64'd0);
      advance();
    end
    m_tready = 1'b1;
    settle();
    chk("stall_release_data", 64'(m_if.tdata), 64'(pat(2, pktno[2], 1)));
    chk("stall_release_tready", 64'(s_if.tready), 64'b0100);
    advance();
    run_until(1, 10, "stall_done");
    chk("stall_src", 64'(done_q[0]), 64'd2);

    // Port 1 mid-packet while ports 0 and 3 start requesting.
    do_reset();
    rem[1] = 4;
    tick();
    tick();
    rem[0] = 2;
    rem[3] = 2;
    run_until(3, 40, "lock_done");
    chk("lock_order0", 64'(done_q[0]), 64'd1);
    chk("lock_order1", 64'(done_q[1]), 64'd3);
    chk("lock_order2", 64'(done_q[2]), 64'd0);

    // Granted port 0 drops tvalid for three cycles mid-packet.
    do_reset();
    rem[0] = 4;
    tick();
    tick();
    rem[1]  = 2;
    hold[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("gap_busy", 64'(busy), 64'd1);
      chk("gap_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("gap_m_tid", 64'(m_if.tid), 64'd0);
      chk("gap_s_tready1", 64'(s_if.tready[1]), 64'd0);
      advance();
    end
    hold[0] = 1'b0;
    run_until(2, 30, "gap_done");
    chk("gap_order0", 64'(done_q[0]), 64'd0);
    chk("gap_order1", 64'(done_q[1]), 64'd1);

    // Asynchronous reset in the middle of port 2's packet.
    do_reset();
    rem[2] = 4;
    tick();
    tick();
    drive_inputs();
    #2;
    chk("pre_reset_valid", 64'(m_if.tvalid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("async_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("async_s_tready", 64'(s_if.tready), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    do_reset();
    rem[1] = 2;
    rem[2] = 2;
    run_until(2, 20, "post_reset_done");
    chk("post_reset_first", 64'(done_q[0]), 64'd1);
    chk("post_reset_second", 64'(done_q[1]), 64'd2);

    // Random requests, gaps and backpressure against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 4));
        hold[i] = ($urandom_range(0, 7) == 0);
      end
      m_tready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
